// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, downstream
// valid/ready/data and the stage flush. slave = the stage, master = its environment.
interface pipe_stage_reg_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             flush;

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional saturating stall/bubble counters when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   parameter int unsigned     CNT_W      = 16
`endif
) (
   input logic             clk,
   input logic             rst,
   pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic             in_ready_c;
   logic             accept_c;

   // in_ready comes straight from the skid flop; rst only masks it
   assign in_ready_c = ~skid_valid_q & ~rst;
   assign accept_c   = bus.in_valid & in_ready_c;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (~out_valid_q | bus.out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         skid_valid_d = 1'b1;
         skid_data_d  = bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= RESET_DATA;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating counters; flush does not clear them
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (!out_valid_q && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, FIFO-model random run and,
// with PIPE_STAGE_PERF_CNT_EN, counter saturation checks.
module tb_pipe_stage_reg;
   localparam int unsigned     W        = 32;
   localparam logic [W-1:0]    RST_DATA = 32'hDEAD_0000;
`ifdef PIPE_STAGE_PERF_CNT_EN
   localparam int unsigned     CNT_W    = 4;
   localparam int              CNT_MAX  = (1 << CNT_W) - 1;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;
`endif

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   pipe_stage_reg_if #(.WIDTH(W)) bus ();

`ifdef PIPE_STAGE_PERF_CNT_EN
   pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RST_DATA), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));
`else
   pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RST_DATA)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic         flush;
      logic         iv;
      logic [W-1:0] d;
      logic         ord;
      logic         ev;
      logic [W-1:0] ed;
      logic         er;
   } vec_t;

   vec_t tbl[22];

   // Reference: a FIFO of at most two entries plus the last shown payload
   logic [W-1:0] q[$];
   logic [W-1:0] last_data;
   int           m_stall, m_bubble;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ord);
      rst           = r;
      bus.flush     = f;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ord;
   endtask

   function automatic logic model_ready();
      return (q.size() < 2) && !rst;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      logic acc;
      acc = bus.in_valid && model_ready();
      if (rst) begin
         q.delete();
         last_data = RST_DATA;
         m_stall   = 0;
         m_bubble  = 0;
      end else begin
         if (q.size() > 0 && !bus.out_ready) m_stall = (m_stall < CNT_MAX_M()) ? m_stall + 1 : m_stall;
         if (q.size() == 0) m_bubble = (m_bubble < CNT_MAX_M()) ? m_bubble + 1 : m_bubble;
         if (bus.flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (acc) q.push_back(bus.in_data);
         end
      end
      if (q.size() > 0) last_data = q[0];
   endtask

   function automatic int CNT_MAX_M();
`ifdef PIPE_STAGE_PERF_CNT_EN
      return CNT_MAX;
`else
      return 32'h7fff_ffff;
`endif
   endfunction

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      // test 1: streaming at full rate
      tbl[0]  = '{0,0,1,32'h11,1, 1,32'h11,1};
      tbl[1]  = '{0,0,1,32'h22,1, 1,32'h22,1};
      tbl[2]  = '{0,0,1,32'h33,1, 1,32'h33,1};
      tbl[3]  = '{0,0,0,32'h00,1, 0,32'h33,1};
      // test 2: backpressure fills skid, then drains in order
      tbl[4]  = '{0,0,1,32'h0A,0, 1,32'h0A,1};
      tbl[5]  = '{0,0,1,32'h0B,0, 1,32'h0A,0};
      tbl[6]  = '{0,0,1,32'h0C,0, 1,32'h0A,0};
      tbl[7]  = '{0,0,1,32'h0C,1, 1,32'h0B,1};
      tbl[8]  = '{0,0,1,32'h0C,1, 1,32'h0C,1};
      tbl[9]  = '{0,0,0,32'h00,1, 0,32'h0C,1};
      // test 3: flush with both entries full
      tbl[10] = '{0,0,1,32'h05,0, 1,32'h05,1};
      tbl[11] = '{0,0,1,32'h06,0, 1,32'h05,0};
      tbl[12] = '{0,1,0,32'h00,0, 0,32'h05,1};
      tbl[13] = '{0,0,1,32'h07,1, 1,32'h07,1};
      tbl[14] = '{0,0,0,32'h00,1, 0,32'h07,1};
      // test 4: accept in the flush cycle is dropped
      tbl[15] = '{0,1,1,32'h99,1, 0,32'h07,1};
      tbl[16] = '{0,0,0,32'h00,1, 0,32'h07,1};
      // test 5: reset with skid full, then reset together with flush
      tbl[17] = '{0,0,1,32'h01,0, 1,32'h01,1};
      tbl[18] = '{0,0,1,32'h02,0, 1,32'h01,0};
      tbl[19] = '{1,0,0,32'h00,0, 0,RST_DATA,0};
      tbl[20] = '{1,1,0,32'h00,0, 0,RST_DATA,0};
      tbl[21] = '{0,0,0,32'h00,0, 0,RST_DATA,1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_out_data", bus.out_data, RST_DATA);
      chk("post_rst_in_ready", {31'b0, bus.in_ready}, 1);

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ord);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ev});
         chk($sformatf("vec%0d_out_data", i),  bus.out_data, tbl[i].ed);
         chk($sformatf("vec%0d_in_ready", i),  {31'b0, bus.in_ready}, {31'b0, tbl[i].er});
      end

      // random run against the FIFO model
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < 800; c++) begin
         drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 20) == 0),
               1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0));
         #1;
         chk("rnd_in_ready", {31'b0, bus.in_ready}, {31'b0, model_ready()});
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_out_valid", {31'b0, bus.out_valid}, {31'b0, (q.size() > 0)});
         chk("rnd_out_data", bus.out_data, last_data);
`ifdef PIPE_STAGE_PERF_CNT_EN
         chk("rnd_stall_cnt",  W'(stall_cnt),  W'(m_stall));
         chk("rnd_bubble_cnt", W'(bubble_cnt), W'(m_bubble));
`endif
      end

`ifdef PIPE_STAGE_PERF_CNT_EN
      // test 6: stall counter saturation, flush keeps it, reset clears both
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("sat_out_valid", {31'b0, bus.out_valid}, 1);
      chk("sat_stall_cnt", W'(stall_cnt), W'(CNT_MAX));
      drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      chk("flush_stall_cnt", W'(stall_cnt), W'(CNT_MAX));
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      chk("rst_stall_cnt",  W'(stall_cnt),  0);
      chk("rst_bubble_cnt", W'(bubble_cnt), 0);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
